// File: rtl/lcd_framebuffer_writer_if.sv
// Framebuffer BRAM write port: linear address, data and write request, with ready backpressure.
// Data is 16-bit RGB565 when FB_RGB_EN is defined, otherwise the raw 2-bit shade.
interface lcd_framebuffer_writer_if #(
    parameter int X_MAX = 160,
    parameter int Y_MAX = 144
);
    localparam int ADDR_W = $clog2(X_MAX * Y_MAX);
`ifdef FB_RGB_EN
    localparam int DATA_W = 16;
`else
    localparam int DATA_W = 2;
`endif

    logic [ADDR_W-1:0] fb_addr_out;
    logic [DATA_W-1:0] fb_data_out;
    logic              fb_we_out;
    logic              fb_ready_in;

    modport master (
        output fb_addr_out,
        output fb_data_out,
        output fb_we_out,
        input  fb_ready_in
    );

    modport slave (
        input  fb_addr_out,
        input  fb_data_out,
        input  fb_we_out,
        output fb_ready_in
    );
endinterface

// File: rtl/lcd_framebuffer_writer.sv
// Writes PPU pixel shades into the framebuffer BRAM through a skid FIFO, blanking when the LCD turns off.
// Optional macro FB_RGB_EN: convert shades to RGB565 and blank with the shade-0 colour.
module lcd_framebuffer_writer #(
    parameter int X_MAX      = 160,
    parameter int Y_MAX      = 144,
    parameter int SKID_DEPTH = 4,
    localparam int X_W       = $clog2(X_MAX),
    localparam int Y_W       = $clog2(Y_MAX)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [1:0]                      pixel_in,
    input  logic                            pixel_valid_in,
    input  logic                            frame_start_in,
    input  logic                            lcd_enable_in,
    lcd_framebuffer_writer_if.master        fb,
    output logic [X_W-1:0]                  x_out,
    output logic [Y_W-1:0]                  y_out,
    output logic                            frame_done_out,
    output logic                            overflow_out
);
    localparam int ADDR_W = $clog2(X_MAX * Y_MAX);
    localparam int PTR_W  = $clog2(SKID_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(X_MAX * Y_MAX - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(X_MAX - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(SKID_DEPTH);
`ifdef FB_RGB_EN
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] BLANK_DATA = 16'hE7DA;
`else
    localparam int DATA_W = 2;
    localparam logic [DATA_W-1:0] BLANK_DATA = 2'b00;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        BLANK  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              lcd_en_q, lcd_en_d;
    logic              overflow_q, overflow_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        mem_q [SKID_DEPTH];
    logic [1:0]        mem_d [SKID_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic fb_we;
    logic accept;
    logic at_last;
    logic lcd_fall;
    logic push;
    logic push_ok;
    logic pop;
    logic flush;
    logic clear_pos;
    logic advance;

    function automatic logic [DATA_W-1:0] shade_to_data(input logic [1:0] shade);
        logic [DATA_W-1:0] result;
`ifdef FB_RGB_EN
        case (shade)
            2'd0:    result = 16'hE7DA;
            2'd1:    result = 16'h8E0E;
            2'd2:    result = 16'h334A;
            default: result = 16'h08C4;
        endcase
`else
        result = shade;
`endif
        return result;
    endfunction

    always_comb begin
        fb_we    = ((state_q == ACTIVE) && (count_q != '0)) || (state_q == BLANK);
        accept   = fb_we && fb.fb_ready_in;
        at_last  = (addr_q == LAST_ADDR);
        lcd_fall = lcd_en_q && !lcd_enable_in;
    end

    // Data is forced to zero whenever no write is requested so idle outputs stay quiet.
    always_comb begin
        fb.fb_data_out = '0;
        if (fb_we) begin
            if (state_q == BLANK) begin
                fb.fb_data_out = BLANK_DATA;
            end else begin
                fb.fb_data_out = shade_to_data(mem_q[rd_ptr_q]);
            end
        end
    end

    assign fb.fb_we_out   = fb_we;
    assign fb.fb_addr_out = addr_q;
    assign x_out          = x_q;
    assign y_out          = y_q;
    assign frame_done_out = accept && at_last;
    assign overflow_out   = overflow_q;

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        lcd_en_d   = lcd_enable_in;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        push       = 1'b0;
        push_ok    = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        clear_pos  = 1'b0;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_start_in && lcd_enable_in) begin
                    state_d   = ACTIVE;
                    flush     = 1'b1;
                    clear_pos = 1'b1;
                    push      = pixel_valid_in;
                end
            end
            ACTIVE: begin
                // A restart before the last write counts as a short frame.
                if (frame_start_in) begin
                    flush     = 1'b1;
                    clear_pos = 1'b1;
                    push      = pixel_valid_in;
                    if (!(accept && at_last)) begin
                        overflow_d = 1'b1;
                    end
                end else if (accept && at_last) begin
                    state_d   = DONE;
                    flush     = 1'b1;
                    clear_pos = 1'b1;
                    if (pixel_valid_in || (count_q > CNT_W'(1))) begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    pop     = accept;
                    advance = accept;
                    push    = pixel_valid_in;
                end
            end
            DONE: begin
                if (frame_start_in) begin
                    state_d   = ACTIVE;
                    flush     = 1'b1;
                    clear_pos = 1'b1;
                    push      = pixel_valid_in;
                end else if (pixel_valid_in) begin
                    overflow_d = 1'b1;
                end
            end
            BLANK: begin
                if (accept) begin
                    if (at_last) begin
                        state_d   = IDLE;
                        clear_pos = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (lcd_fall) begin
            state_d   = BLANK;
            flush     = 1'b1;
            clear_pos = 1'b1;
            push      = 1'b0;
            pop       = 1'b0;
            advance   = 1'b0;
        end

        if (clear_pos) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (advance) begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == LAST_X) begin
                x_d = '0;
                y_d = y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end

        // A full FIFO still takes a push when the head leaves in the same cycle.
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (push) begin
                mem_d[0] = pixel_in;
                wr_ptr_d = PTR_W'(1);
                count_d  = CNT_W'(1);
            end
        end else begin
            push_ok = push && ((count_q != FULL_CNT) || pop);
            if (push && !push_ok) begin
                overflow_d = 1'b1;
            end
            if (push_ok) begin
                mem_d[wr_ptr_q] = pixel_in;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            lcd_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            mem_q      <= '{default: 2'b00};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            lcd_en_q   <= lcd_en_d;
            overflow_q <= overflow_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end
endmodule
